// File: rtl/brick_game_ctrl_pkg.sv
// Shared definitions for the brick game sequencer: FSM state codes,
// default sizing and the saturating score adder.
package brick_game_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_SERVE = 3'd0,
      ST_PLAY  = 3'd1,
      ST_LOST  = 3'd2,
      ST_CLEAR = 3'd3,
      ST_OVER  = 3'd4
   } state_e;

   localparam int DEF_NUM_BRICKS = 10;
   localparam int DEF_LIVES      = 3;
   localparam int DEF_SCORE_W    = 8;
   localparam int DEF_PTS        = 1;

   // Adds b to a and clamps the result at max_v.
   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] max_v);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum > {1'b0, max_v}) begin
         return max_v;
      end
      return sum[31:0];
   endfunction

endpackage

// File: rtl/brick_priority_arb.sv
// Find-first-set arbiter: the lowest-index requesting brick wins.
module brick_priority_arb #(
   parameter int  NB = 10,
   localparam int IW = $clog2(NB)
) (
   input  logic [NB-1:0] req_i,
   output logic          gnt_valid_o,
   output logic [IW-1:0] gnt_idx_o
);

   // Scan downwards so the last match seen is the lowest index.
   always_comb begin
      gnt_valid_o = 1'b0;
      gnt_idx_o   = '0;
      for (int i = NB - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            gnt_valid_o = 1'b1;
            gnt_idx_o   = IW'(i);
         end
      end
   end

endmodule

// File: rtl/brick_game_ctrl.sv
// Game-level sequencer: brick alive vector, one hit per frame, score,
// remaining balls and the serve/play/lost/clear/over state machine.
module brick_game_ctrl
   import brick_game_ctrl_pkg::*;
#(
   parameter int  NUM_BRICKS = DEF_NUM_BRICKS,
   parameter int  LIVES      = DEF_LIVES,
   parameter int  SCORE_W    = DEF_SCORE_W,
   parameter int  PTS        = DEF_PTS,
   localparam int IDX_W      = $clog2(NUM_BRICKS)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  frame_tick_i,
   input  logic                  start_i,
   input  logic [NUM_BRICKS-1:0] collide_i,
   input  logic                  ball_lost_i,
   output logic [NUM_BRICKS-1:0] alive_o,
   output logic                  hit_valid_o,
   output logic [IDX_W-1:0]      hit_idx_o,
   output logic                  ball_run_o,
   output logic                  ball_reset_o,
   output logic [SCORE_W-1:0]    score_o,
   output logic [2:0]            lives_o,
   output logic [2:0]            state_o,
   output logic                  level_clear_o,
   output logic                  game_over_o
);

   localparam logic [31:0] SCORE_MAX  = (32'd1 << SCORE_W) - 32'd1;
   localparam logic [2:0]  LIVES_INIT = 3'(LIVES);

   state_e                  state_q, state_d;
   logic                    start_q;
   logic                    frame_lock_q, frame_lock_d;
   logic [NUM_BRICKS-1:0]   alive_q, alive_d;
   logic [SCORE_W-1:0]      score_q, score_d;
   logic [2:0]              lives_q, lives_d;
   logic                    hit_valid_q, hit_valid_d;
   logic [IDX_W-1:0]        hit_idx_q, hit_idx_d;
   logic                    ball_reset_q, ball_reset_d;
   logic                    ball_run_q, ball_run_d;
   logic                    level_clear_q, level_clear_d;
   logic                    game_over_q, game_over_d;

   logic                    start_rise;
   logic                    gnt_valid;
   logic                    grant;
   logic [IDX_W-1:0]        gnt_idx;
   logic [NUM_BRICKS-1:0]   gnt_mask;

   assign start_rise = start_i & ~start_q;

   brick_priority_arb #(.NB(NUM_BRICKS)) u_arb (
      .req_i       (collide_i & alive_q),
      .gnt_valid_o (gnt_valid),
      .gnt_idx_o   (gnt_idx)
   );

   // A hit is granted only while playing and only once per frame.
   assign grant    = (state_q == ST_PLAY) & gnt_valid & ~frame_lock_q;
   assign gnt_mask = NUM_BRICKS'(1) << gnt_idx;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_SERVE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      alive_d      = alive_q;
      score_d      = score_q;
      lives_d      = lives_q;
      hit_valid_d  = 1'b0;
      hit_idx_d    = hit_idx_q;
      ball_reset_d = 1'b0;
      frame_lock_d = frame_lock_q;
      if (grant) begin
         frame_lock_d = 1'b1;
      end else if (frame_tick_i) begin
         frame_lock_d = 1'b0;
      end
      unique case (state_q)
         ST_SERVE: begin
            if (start_rise) state_d = ST_PLAY;
         end
         ST_PLAY: begin
            if (grant) begin
               alive_d     = alive_q & ~gnt_mask;
               hit_valid_d = 1'b1;
               hit_idx_d   = gnt_idx;
               score_d     = SCORE_W'(sat_add(32'(score_q), 32'(PTS), SCORE_MAX));
            end
            // Clearing the field wins over a ball lost in the same cycle.
            if (grant && (alive_d == '0)) begin
               state_d = ST_CLEAR;
            end else if (ball_lost_i) begin
               state_d = ST_LOST;
               lives_d = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
            end
         end
         ST_LOST: begin
            if (lives_q == 3'd0) begin
               state_d = ST_OVER;
            end else begin
               ball_reset_d = 1'b1;
               state_d      = ST_SERVE;
            end
         end
         ST_CLEAR: begin
            if (start_rise) begin
               alive_d      = '1;
               ball_reset_d = 1'b1;
               state_d      = ST_SERVE;
            end
         end
         ST_OVER: begin
            if (start_rise) begin
               score_d      = '0;
               lives_d      = LIVES_INIT;
               alive_d      = '1;
               ball_reset_d = 1'b1;
               state_d      = ST_SERVE;
            end
         end
         default: state_d = ST_SERVE;
      endcase
   end

   always_comb begin
      ball_run_d    = (state_d == ST_PLAY);
      level_clear_d = (state_d == ST_CLEAR);
      game_over_d   = (state_d == ST_OVER);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         start_q       <= 1'b0;
         frame_lock_q  <= 1'b0;
         alive_q       <= '1;
         score_q       <= '0;
         lives_q       <= LIVES_INIT;
         hit_valid_q   <= 1'b0;
         hit_idx_q     <= '0;
         ball_reset_q  <= 1'b0;
         ball_run_q    <= 1'b0;
         level_clear_q <= 1'b0;
         game_over_q   <= 1'b0;
      end else begin
         start_q       <= start_i;
         frame_lock_q  <= frame_lock_d;
         alive_q       <= alive_d;
         score_q       <= score_d;
         lives_q       <= lives_d;
         hit_valid_q   <= hit_valid_d;
         hit_idx_q     <= hit_idx_d;
         ball_reset_q  <= ball_reset_d;
         ball_run_q    <= ball_run_d;
         level_clear_q <= level_clear_d;
         game_over_q   <= game_over_d;
      end
   end

   assign alive_o       = alive_q;
   assign hit_valid_o   = hit_valid_q;
   assign hit_idx_o     = hit_idx_q;
   assign ball_run_o    = ball_run_q;
   assign ball_reset_o  = ball_reset_q;
   assign score_o       = score_q;
   assign lives_o       = lives_q;
   assign state_o       = state_q;
   assign level_clear_o = level_clear_q;
   assign game_over_o   = game_over_q;

endmodule

// File: tb/tb_brick_game_ctrl.sv
// Self-checking bench for brick_game_ctrl: directed scenarios plus random
// play checked against a rule-level game model.
module tb_brick_game_ctrl;

   localparam int NB = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, start, ft, lost;
   logic [NB-1:0] collide;
   logic [NB-1:0] alive;
   logic          hit_valid, ball_run, ball_reset, level_clear, game_over;
   logic [3:0]    hit_idx;
   logic [7:0]    score;
   logic [2:0]    lives, state;

   logic          rst2_n, start2, ft2, lost2;
   logic [NB-1:0] collide2;
   logic [NB-1:0] alive2;
   logic          hit_valid2, ball_run2, ball_reset2, level_clear2, game_over2;
   logic [3:0]    hit_idx2;
   logic [3:0]    score2;
   logic [2:0]    lives2, state2;

   brick_game_ctrl u_dut (
      .clk_i(clk), .rst_ni(rst_n), .frame_tick_i(ft), .start_i(start),
      .collide_i(collide), .ball_lost_i(lost), .alive_o(alive),
      .hit_valid_o(hit_valid), .hit_idx_o(hit_idx), .ball_run_o(ball_run),
      .ball_reset_o(ball_reset), .score_o(score), .lives_o(lives),
      .state_o(state), .level_clear_o(level_clear), .game_over_o(game_over)
   );

   brick_game_ctrl #(.SCORE_W(4), .PTS(3)) u_sat (
      .clk_i(clk), .rst_ni(rst2_n), .frame_tick_i(ft2), .start_i(start2),
      .collide_i(collide2), .ball_lost_i(lost2), .alive_o(alive2),
      .hit_valid_o(hit_valid2), .hit_idx_o(hit_idx2), .ball_run_o(ball_run2),
      .ball_reset_o(ball_reset2), .score_o(score2), .lives_o(lives2),
      .state_o(state2), .level_clear_o(level_clear2), .game_over_o(game_over2)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Rule-level game model for the default-parameter instance.
   logic [NB-1:0] m_alive;
   int            m_score, m_lives, m_state, m_idx;
   bit            m_lock, m_start_prev, m_hv, m_br;

   logic [32:0] got_vec;
   assign got_vec = {alive, hit_valid, hit_idx, ball_run, ball_reset, score,
                     lives, state, level_clear, game_over};

   function automatic logic [32:0] exp_vec();
      return {m_alive, m_hv, 4'(m_idx), 1'(m_state == 1), m_br, 8'(m_score),
              3'(m_lives), 3'(m_state), 1'(m_state == 3), 1'(m_state == 4)};
   endfunction

   task automatic model_reset();
      m_alive = '1; m_score = 0; m_lives = 3; m_state = 0; m_idx = 0;
      m_lock = 0; m_start_prev = 0; m_hv = 0; m_br = 0;
   endtask

   task automatic model_step();
      bit rise, granted;
      int win, ns;
      logic [NB-1:0] req;
      rise = start && !m_start_prev;
      granted = 0; win = -1; ns = m_state;
      m_hv = 0; m_br = 0;
      case (m_state)
         0: if (rise) ns = 1;
         1: begin
            req = collide & m_alive;
            if (!m_lock) begin
               for (int i = 0; i < NB; i++) if (req[i] && win < 0) win = i;
            end
            if (win >= 0) begin
               granted = 1;
               m_alive[win] = 1'b0;
               m_score = (m_score + 1 > 255) ? 255 : m_score + 1;
               m_idx = win;
               m_hv = 1;
            end
            if (granted && m_alive == '0) ns = 3;
            else if (lost) begin
               ns = 2;
               if (m_lives > 0) m_lives = m_lives - 1;
            end
         end
         2: begin
            if (m_lives == 0) ns = 4;
            else begin m_br = 1; ns = 0; end
         end
         3: if (rise) begin m_alive = '1; m_br = 1; ns = 0; end
         default: if (rise) begin
            m_score = 0; m_lives = 3; m_alive = '1; m_br = 1; ns = 0;
         end
      endcase
      if (granted) m_lock = 1;
      else if (ft) m_lock = 0;
      m_state = ns;
      m_start_prev = start;
   endtask

   task automatic step();
      if (!rst_n) model_reset();
      else model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic go_play();
      start = 1; step();
      start = 0; step();
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4; i++) begin
         start = ~start;
         step();
         n_checks++;
         if (got_vec !== {10'h3FF, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0, 3'd3, 3'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected %h", got_vec,
                     {10'h3FF, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0, 3'd3, 3'd0, 1'b0, 1'b0});
         end
      end
      start = 0; step();
      rst_n = 1; rst2_n = 1;
      step();
      n_checks++;
      if ({state, ball_run} !== {3'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_release: state=%0d run=%b expected 0/0", state, ball_run);
      end
   endtask

   task automatic test_arbitration();
      go_play();
      n_checks++;
      if ({state, ball_run} !== {3'd1, 1'b1}) begin
         n_fail++;
         $display("FAIL arb_play: state=%0d run=%b expected 1/1", state, ball_run);
      end
      collide = 10'b0000010100;
      step();
      n_checks++;
      if ({alive, hit_valid, hit_idx, score} !== {10'h3FB, 1'b1, 4'd2, 8'd1}) begin
         n_fail++;
         $display("FAIL arb_first: alive=%h hv=%b idx=%0d score=%0d expected 3fb/1/2/1",
                  alive, hit_valid, hit_idx, score);
      end
      step();
      n_checks++;
      if ({alive, hit_valid, score} !== {10'h3FB, 1'b0, 8'd1}) begin
         n_fail++;
         $display("FAIL arb_locked: alive=%h hv=%b score=%0d expected 3fb/0/1", alive, hit_valid, score);
      end
      ft = 1; step(); ft = 0;
      n_checks++;
      if (hit_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL arb_tick_cycle: hv=%b expected 0", hit_valid);
      end
      step();
      n_checks++;
      if ({alive, hit_valid, hit_idx, score} !== {10'h3EB, 1'b1, 4'd4, 8'd2}) begin
         n_fail++;
         $display("FAIL arb_second: alive=%h hv=%b idx=%0d score=%0d expected 3eb/1/4/2",
                  alive, hit_valid, hit_idx, score);
      end
      collide = '0;
      ft = 1; step(); ft = 0;
      n_checks++;
      if (got_vec !== exp_vec()) begin
         n_fail++;
         $display("FAIL arb_model: got %h expected %h", got_vec, exp_vec());
      end
   endtask

   task automatic test_frame_lock();
      int hits;
      hits = 0;
      collide = 10'h020;
      for (int f = 0; f < 3; f++) begin
         for (int c = 0; c < 6; c++) begin
            ft = (c == 5);
            step();
            if (hit_valid) hits++;
         end
      end
      ft = 0; collide = '0;
      n_checks++;
      if (hits != 1) begin
         n_fail++;
         $display("FAIL lock_hits: got %0d hit pulses expected 1", hits);
      end
      n_checks++;
      if ({alive, score} !== {10'h3CB, 8'd3}) begin
         n_fail++;
         $display("FAIL lock_score: alive=%h score=%0d expected 3cb/3", alive, score);
      end
   endtask

   task automatic test_lives();
      int resets;
      resets = 0;
      rst_n = 0; step(); rst_n = 1;
      for (int k = 1; k <= 3; k++) begin
         go_play();
         lost = 1; step(); lost = 0;
         n_checks++;
         if ({state, lives, ball_run} !== {3'd2, 3'(3 - k), 1'b0}) begin
            n_fail++;
            $display("FAIL lives_lost%0d: state=%0d lives=%0d run=%b expected 2/%0d/0",
                     k, state, lives, ball_run, 3 - k);
         end
         step();
         if (ball_reset) resets++;
         if (k < 3) begin
            n_checks++;
            if ({state, ball_reset} !== {3'd0, 1'b1}) begin
               n_fail++;
               $display("FAIL lives_serve%0d: state=%0d br=%b expected 0/1", k, state, ball_reset);
            end
         end else begin
            n_checks++;
            if ({state, game_over, ball_reset} !== {3'd4, 1'b1, 1'b0}) begin
               n_fail++;
               $display("FAIL lives_over: state=%0d go=%b br=%b expected 4/1/0",
                        state, game_over, ball_reset);
            end
         end
      end
      lost = 1; step(); lost = 0;
      if (ball_reset) resets++;
      n_checks++;
      if (resets != 2) begin
         n_fail++;
         $display("FAIL lives_resets: got %0d ball_reset pulses expected 2", resets);
      end
      n_checks++;
      if ({lives, state} !== {3'd0, 3'd4}) begin
         n_fail++;
         $display("FAIL lives_floor: lives=%0d state=%0d expected 0/4", lives, state);
      end
   endtask

   task automatic test_clear_race();
      rst_n = 0; step(); rst_n = 1;
      go_play();
      for (int i = 0; i < NB - 1; i++) begin
         collide = 10'(1 << i);
         step();
         collide = '0;
         n_checks++;
         if ({hit_valid, hit_idx} !== {1'b1, 4'(i)}) begin
            n_fail++;
            $display("FAIL clear_hit%0d: hv=%b idx=%0d expected 1/%0d", i, hit_valid, hit_idx, i);
         end
         ft = 1; step(); ft = 0;
      end
      collide = 10'h200; lost = 1;
      step();
      collide = '0; lost = 0;
      n_checks++;
      if ({state, lives, level_clear, alive, score, hit_idx} !==
          {3'd3, 3'd3, 1'b1, 10'h000, 8'd10, 4'd9}) begin
         n_fail++;
         $display("FAIL clear_race: state=%0d lives=%0d lc=%b alive=%h score=%0d idx=%0d expected 3/3/1/000/10/9",
                  state, lives, level_clear, alive, score, hit_idx);
      end
      step();
      start = 1; step(); start = 0;
      n_checks++;
      if ({state, alive, ball_reset, score, lives, level_clear} !==
          {3'd0, 10'h3FF, 1'b1, 8'd10, 3'd3, 1'b0}) begin
         n_fail++;
         $display("FAIL clear_restart: state=%0d alive=%h br=%b score=%0d lives=%0d lc=%b expected 0/3ff/1/10/3/0",
                  state, alive, ball_reset, score, lives, level_clear);
      end
   endtask

   task automatic test_reset_mid_play();
      go_play();
      collide = 10'h001;
      step();
      collide = '0;
      #2 rst_n = 0;
      #1;
      n_checks++;
      if ({alive, score, lives, state, hit_valid, ball_run, ball_reset} !==
          {10'h3FF, 8'd0, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_async: alive=%h score=%0d lives=%0d state=%0d hv=%b run=%b br=%b",
                  alive, score, lives, state, hit_valid, ball_run, ball_reset);
      end
      step();
      rst_n = 1;
      step();
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 800; cyc++) begin
         if ($urandom_range(0, 5) == 0) start = ~start;
         if ($urandom_range(0, 2) == 0)
            collide = 10'($urandom_range(0, 1023) & $urandom_range(0, 1023));
         else
            collide = '0;
         ft   = ($urandom_range(0, 5) == 0);
         lost = ($urandom_range(0, 24) == 0);
         step();
         n_checks++;
         if (got_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL random_cycle%0d: got %h expected %h", cyc, got_vec, exp_vec());
         end
      end
      start = 0; collide = '0; ft = 0; lost = 0;
      step();
   endtask

   task automatic test_saturation();
      int exp_s;
      start2 = 1; step(); start2 = 0;
      n_checks++;
      if (state2 !== 3'd1) begin
         n_fail++;
         $display("FAIL sat_play: state=%0d expected 1", state2);
      end
      for (int k = 1; k <= 6; k++) begin
         exp_s = (3 * k > 15) ? 15 : 3 * k;
         collide2 = 10'(1 << (k - 1));
         step();
         collide2 = '0;
         n_checks++;
         if ({hit_valid2, score2} !== {1'b1, 4'(exp_s)}) begin
            n_fail++;
            $display("FAIL sat_hit%0d: hv=%b score=%0d expected 1/%0d", k, hit_valid2, score2, exp_s);
         end
         ft2 = 1; step(); ft2 = 0;
      end
      for (int k = 1; k <= 3; k++) begin
         lost2 = 1; step(); lost2 = 0;
         step();
         if (k < 3) begin start2 = 1; step(); start2 = 0; end
      end
      n_checks++;
      if ({state2, game_over2, score2, lives2} !== {3'd4, 1'b1, 4'd15, 3'd0}) begin
         n_fail++;
         $display("FAIL sat_over: state=%0d go=%b score=%0d lives=%0d expected 4/1/15/0",
                  state2, game_over2, score2, lives2);
      end
      start2 = 1; step(); start2 = 0;
      n_checks++;
      if ({state2, score2, lives2, alive2, ball_reset2, game_over2} !==
          {3'd0, 4'd0, 3'd3, 10'h3FF, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL sat_restart: state=%0d score=%0d lives=%0d alive=%h br=%b go=%b expected 0/0/3/3ff/1/0",
                  state2, score2, lives2, alive2, ball_reset2, game_over2);
      end
   endtask

   initial begin
      rst_n = 0; start = 0; ft = 0; lost = 0; collide = '0;
      rst2_n = 0; start2 = 0; ft2 = 0; lost2 = 0; collide2 = '0;
      model_reset();
      #2;
      test_reset();
      test_arbitration();
      test_frame_lock();
      test_lives();
      test_clear_race();
      test_reset_mid_play();
      test_random();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
